main_fsm: RTL and testbench



---
 rtl/arm_ctrl_pkg.sv | 43 ++++
 rtl/main_fsm_outdec.sv | 62 ++++++
 rtl/main_fsm.sv | 82 ++++++++
 tb/tb_main_fsm.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared encodings for the multicycle main control FSM
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXECR    = 4'd2,
    EXECI    = 4'd3,
    ALUWB    = 4'd4,
    MEMADR   = 4'd5,
    MEMREAD  = 4'd6,
    MEMWRITE = 4'd7,
    MEMWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] SRCB_RM    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] OP_DP      = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BR      = 2'b10;
  localparam logic [1:0] OP_UNDEF   = 2'b11;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
  } ctrl_t;

endpackage

// File: rtl/main_fsm_outdec.sv
// rtl/main_fsm_outdec.sv - Moore output decode, state register value to control vector
module main_fsm_outdec
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.irwrite   = 1'b1;
        ctrl.nextpc    = 1'b1;
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURES;
      end
      DECODE: begin
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURES;
      end
      EXECR: begin
        ctrl.alusrcb   = SRCB_RM;
        ctrl.aluop     = 1'b1;
      end
      EXECI: begin
        ctrl.alusrcb   = SRCB_IMM;
        ctrl.aluop     = 1'b1;
      end
      ALUWB: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regw      = 1'b1;
      end
      MEMADR: begin
        ctrl.alusrcb   = SRCB_IMM;
      end
      MEMREAD: begin
        ctrl.adrsrc    = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
      end
      MEMWB: begin
        ctrl.resultsrc = RES_RDATA;
        ctrl.regw      = 1'b1;
      end
      MEMWRITE: begin
        ctrl.adrsrc    = 1'b1;
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.memw      = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrcb   = SRCB_IMM;
        ctrl.resultsrc = RES_ALURES;
        ctrl.branch    = 1'b1;
      end
      // unused encodings leave every enable low
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle fetch/decode/execute/writeback sequencer for the ARM-subset datapath
module main_fsm
  import arm_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       undef,
  output logic [3:0] state_o
);

  logic [3:0] state_q, state_d;
  logic       rdy;
  ctrl_t      ctrl;
  logic       unused_funct;

  assign rdy          = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = rdy ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_DP:   state_d = Funct[5] ? EXECI : EXECR;
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = rdy ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = rdy ? FETCH : MEMWRITE;
      BRANCH:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  main_fsm_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // enables are masked by reset_n so an async reset kills them in the same cycle
  assign IRWrite   = ctrl.irwrite & rdy & reset_n;
  assign NextPC    = ctrl.nextpc & rdy & reset_n;
  assign RegW      = ctrl.regw & reset_n;
  assign MemW      = ctrl.memw & reset_n;
  assign Branch    = ctrl.branch & reset_n;
  assign undef     = (state_q == DECODE) & (Op == OP_UNDEF) & reset_n;
  assign AdrSrc    = ctrl.adrsrc;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign ResultSrc = ctrl.resultsrc;
  assign ALUOp     = ctrl.aluop;
  assign state_o   = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - directed self-checking bench for main_fsm
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b000000;
  logic       mem_ready = 1'b1;
  logic       IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUOp, undef;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  main_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Op        (Op),
    .Funct     (Funct),
    .mem_ready (mem_ready),
    .IRWrite   (IRWrite),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .undef     (undef),
    .state_o   (state_o)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
    checks++;
    if ({IRWrite, NextPC, RegW, MemW, Branch, undef} !== 6'b0) begin
      errors++; $display("FAIL reset_enables got %b want 000000", {IRWrite, NextPC, RegW, MemW, Branch, undef});
    end
    checks++;
    if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} !== 6'b0_1_10_10) begin
      errors++; $display("FAIL reset_selects got %b want 011010", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc});
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (IRWrite !== 1'b1) begin errors++; $display("FAIL release_irwrite got %b want 1", IRWrite); end
  endtask

  task automatic test_add();
    int exp_st[4] = '{0, 1, 2, 4};
    Op = 2'b00; Funct = 6'b001000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state_o !== exp_st[i][3:0]) begin errors++; $display("FAIL add_state[%0d] got %0d want %0d", i, state_o, exp_st[i]); end
      checks++;
      if (ALUOp !== (i == 2)) begin errors++; $display("FAIL add_aluop[%0d] got %b want %b", i, ALUOp, (i == 2)); end
      checks++;
      if (RegW !== (i == 3)) begin errors++; $display("FAIL add_regw[%0d] got %b want %b", i, RegW, (i == 3)); end
      @(negedge clk);
    end
    #1;
    checks++;
    if (state_o !== 4'd0) begin errors++; $display("FAIL add_done got %0d want 0", state_o); end
  endtask

  task automatic test_ldr_wait();
    int   exp_st[7] = '{0, 1, 5, 6, 6, 6, 8};
    logic rdy[7]    = '{1, 1, 1, 0, 0, 1, 1};
    Op = 2'b01; Funct = 6'b011001;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (state_o !== exp_st[i][3:0]) begin errors++; $display("FAIL ldr_state[%0d] got %0d want %0d", i, state_o, exp_st[i]); end
      checks++;
      if (RegW !== (i == 6)) begin errors++; $display("FAIL ldr_regw[%0d] got %b want %b", i, RegW, (i == 6)); end
      if (i == 6) begin
        checks++;
        if (ResultSrc !== 2'b01) begin errors++; $display("FAIL ldr_resultsrc got %b want 01", ResultSrc); end
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state_o !== 4'd0) begin errors++; $display("FAIL ldr_done got %0d want 0", state_o); end
  endtask

  task automatic test_str_wait();
    int   exp_st[5] = '{0, 1, 5, 7, 7};
    logic rdy[5]    = '{1, 1, 1, 0, 1};
    Op = 2'b01; Funct = 6'b011000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (state_o !== exp_st[i][3:0]) begin errors++; $display("FAIL str_state[%0d] got %0d want %0d", i, state_o, exp_st[i]); end
      checks++;
      if (MemW !== (i >= 3)) begin errors++; $display("FAIL str_memw[%0d] got %b want %b", i, MemW, (i >= 3)); end
      if (i >= 3) begin
        checks++;
        if (AdrSrc !== 1'b1) begin errors++; $display("FAIL str_adrsrc[%0d] got %b want 1", i, AdrSrc); end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (state_o !== 4'd0) begin errors++; $display("FAIL str_done got %0d want 0", state_o); end
  endtask

  task automatic test_branch_undef();
    int exp_st[3] = '{0, 1, 9};
    Op = 2'b10; Funct = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state_o !== exp_st[i][3:0]) begin errors++; $display("FAIL b_state[%0d] got %0d want %0d", i, state_o, exp_st[i]); end
      checks++;
      if (Branch !== (i == 2)) begin errors++; $display("FAIL b_branch[%0d] got %b want %b", i, Branch, (i == 2)); end
      if (i == 2) begin
        checks++;
        if ({ALUSrcB, ResultSrc} !== 4'b01_10) begin errors++; $display("FAIL b_selects got %b want 0110", {ALUSrcB, ResultSrc}); end
      end
      @(negedge clk);
    end
    Op = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (state_o !== i[3:0]) begin errors++; $display("FAIL ud_state[%0d] got %0d want %0d", i, state_o, i); end
      checks++;
      if (undef !== (i == 1)) begin errors++; $display("FAIL ud_pulse[%0d] got %b want %b", i, undef, (i == 1)); end
      if (i == 1) begin
        checks++;
        if ({IRWrite, NextPC, RegW, MemW, Branch} !== 5'b0) begin
          errors++; $display("FAIL ud_enables got %b want 00000", {IRWrite, NextPC, RegW, MemW, Branch});
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({state_o, undef} !== 5'b0000_0) begin errors++; $display("FAIL ud_done got %b want 00000", {state_o, undef}); end
  endtask

  task automatic test_fetch_wait();
    int   exp_st[7] = '{0, 0, 0, 0, 1, 2, 4};
    logic rdy[7]    = '{0, 0, 0, 1, 1, 1, 1};
    Op = 2'b00; Funct = 6'b000000;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (state_o !== exp_st[i][3:0]) begin errors++; $display("FAIL fw_state[%0d] got %0d want %0d", i, state_o, exp_st[i]); end
      checks++;
      if ({IRWrite, NextPC} !== {2{i == 3}}) begin
        errors++; $display("FAIL fw_irw_npc[%0d] got %b want %b", i, {IRWrite, NextPC}, {2{i == 3}});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_memwb();
    int exp_st[4] = '{0, 1, 5, 6};
    Op = 2'b01; Funct = 6'b011001; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state_o !== exp_st[i][3:0]) begin errors++; $display("FAIL rst_pre_state[%0d] got %0d want %0d", i, state_o, exp_st[i]); end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({state_o, RegW} !== 5'b1000_1) begin errors++; $display("FAIL rst_memwb got %b want 10001", {state_o, RegW}); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (RegW !== 1'b0) begin errors++; $display("FAIL rst_regw_drop got %b want 0", RegW); end
    checks++;
    if (state_o !== 4'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state_o); end
    @(negedge clk);
    reset_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (IRWrite !== 1'b0) begin errors++; $display("FAIL rst_irw_notready got %b want 0", IRWrite); end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({state_o, IRWrite} !== 5'b0000_1) begin errors++; $display("FAIL rst_irw_ready got %b want 00001", {state_o, IRWrite}); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr_wait();
    test_str_wait();
    test_branch_undef();
    test_fetch_wait();
    test_reset_mid_memwb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
